muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide execution unit that sits directly downstream of the register file. It latches the two register-file read values (rs, rt) on a start request and computes over 32+ cycles. It then drives a single-cycle write-back (address, enable, data) into the register file's write port, along with a secondary HI result. One operation is in flight at a time, and a busy flag lets the issue logic stall.

## Interface

Parameters:
- raw, 5, register-file address width; sets the width of rd_addr_i and wb_addr_o.

Ports:
- Clocking: one clock (clk); reset is asynchronous and active-low (rst_n).
- clk  input  1  rising-edge clock shared with the register file.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request; sampled only in IDLE.
- op_i  input  2  00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
- rs_val_i  input  32  operand A (multiplicand / dividend), from register-file rs read port.
- rt_val_i  input  32  operand B (multiplier / divisor), from register-file rt read port.
- rd_addr_i  input  raw  destination register, latched with the operands.
- busy_o  output  1  high while an operation is in flight (CALC, FIX, DONE).
- done_o  output  1  one-cycle completion pulse.
- wb_wen_o  output  1  active-high write enable to the register file; equals done_o.
- wb_addr_o  output  raw  latched rd_addr_i.
- wb_data_o  output  32  LO result: product[31:0] or quotient.
- hi_o  output  32  HI result: product[63:32] or remainder.

## Operation

- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i=1 latches op_i, rs_val_i, rt_val_i and rd_addr_i, clears the iteration counter, and moves to CALC.
  - start_i=0 stays in IDLE.
- Operand preparation for signed ops: absolute values are taken at latch time and the result sign is recorded.
  - MUL sign = signA XOR signB.
  - DIV quotient sign = signA XOR signB; remainder sign = signA.
- CALC: 32 iterations at one bit per cycle, then move to FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring division; 33-bit partial remainder, quotient bits shifted in MSB-first.
  - The 5-bit counter wraps 31→0 on the exit transition.
- FIX (1 cycle): applies two's-complement negation per the recorded signs and registers wb_data_o/hi_o, then moves to DONE.
- DONE (1 cycle): done_o=wb_wen_o=1, then return to IDLE.
- Results:
  - Multiply: full 64-bit product; LO to wb_data_o, HI to hi_o.
  - Divide: quotient to wb_data_o, remainder to hi_o.
- Divide by zero (DIVU or DIV): quotient = 0xFFFFFFFF, remainder = dividend unchanged. Full latency still applies; no exception output.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- start_i while busy_o=1 is ignored (no queueing); start_i in the DONE cycle is also ignored.
- The write-back is issued for every destination, including address 0; zero-register policy belongs to the register file.
- wb_addr_o, wb_data_o and hi_o hold their last values until the next FIX; they are valid only while wb_wen_o=1.

## Timing

- Reset: asynchronous clear to IDLE; busy_o, done_o and wb_wen_o = 0; wb_addr_o, wb_data_o and hi_o = 0; all internal operand, counter and sign registers = 0.
- Reset mid-operation aborts immediately, with no write-back. The first start after reset release behaves normally.
- Latency, with start_i sampled high at rising edge 0:
  - busy_o is high from edge 0 until edge 34.
  - done_o and wb_wen_o are high for exactly the cycle between edges 33 and 34.
  - The register file captures the write at edge 34.
- Throughput: the next start is accepted at edge 35 at the earliest, i.e. 35 cycles per operation. Latency is identical for all ops and operand values.
- Operands need only be valid in the start cycle. Later changes on rs_val_i, rt_val_i, op_i or rd_addr_i have no effect.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- MULU 0xFFFFFFFF × 0xFFFFFFFF, rd=7 -> done at cycle 34, wb_addr_o=7, wb_data_o=0x00000001, hi_o=0xFFFFFFFE.
- MUL (−3) × 7 (0xFFFFFFFD, 0x00000007) -> wb_data_o=0xFFFFFFEB, hi_o=0xFFFFFFFF. DIV −7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIVU 100 / 0 -> wb_data_o=0xFFFFFFFF, hi_o=0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> wb_data_o=0x80000000, hi_o=0.
- Start DIVU 1000/7; pulse start_i with different operands at cycles 5 and 34 -> both ignored; result 142 rem 6; busy_o drops after edge 34.
- Start MUL; assert rst_n=0 at cycle 10 -> outputs zero immediately, no wb_wen_o pulse. After release, MULU 6×7 -> wb_data_o=42, hi_o=0, latency 34.
- Back-to-back: random signed/unsigned ops are issued at the earliest accept edge and compared against a 64-bit reference model -> no mismatches, one wb_wen_o pulse per accepted start.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit feeding the register-file write port.
// One operation in flight; fixed 35-cycle issue-to-issue cadence for every op.
module muldiv_unit #(
    parameter int raw = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [1:0]     op_i,
    input  logic [31:0]    rs_val_i,
    input  logic [31:0]    rt_val_i,
    input  logic [raw-1:0] rd_addr_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           wb_wen_o,
    output logic [raw-1:0] wb_addr_o,
    output logic [31:0]    wb_data_o,
    output logic [31:0]    hi_o
);

    // state | meaning
    // IDLE  | waiting for start_i, operands not yet latched
    // CALC  | 32 shift-add / restoring-divide iterations
    // FIX   | apply result signs, register wb_data_o / hi_o
    // DONE  | single-cycle write-back pulse
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state;
    logic           is_div;
    logic           neg_lo;
    logic           neg_hi;
    logic           div_zero;
    logic [31:0]    a_abs;
    logic [31:0]    b_abs;
    logic [4:0]     cnt;
    logic [63:0]    acc;
    logic [31:0]    rem;
    logic [raw-1:0] rd_q;

    logic           sign_a;
    logic           sign_b;
    logic [31:0]    a_in;
    logic [31:0]    b_in;
    logic [32:0]    mul_sum;
    logic [32:0]    rem_sh;
    logic           rem_ge;
    logic [31:0]    rem_sub;
    logic [63:0]    prod_fix;
    logic [31:0]    quo_fix;
    logic [31:0]    rem_fix;

    always_comb begin
        sign_a   = op_i[0] & rs_val_i[31];
        sign_b   = op_i[0] & rt_val_i[31];
        a_in     = sign_a ? (32'd0 - rs_val_i) : rs_val_i;
        b_in     = sign_b ? (32'd0 - rt_val_i) : rt_val_i;
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_abs} : 33'd0);
        // Remainder always stays below the divisor, so the 32-bit subtract is exact.
        rem_sh   = {rem, acc[31]};
        rem_ge   = rem_sh >= {1'b0, b_abs};
        rem_sub  = rem_sh[31:0] - b_abs;
        prod_fix = neg_lo ? (64'd0 - acc) : acc;
        quo_fix  = div_zero ? 32'hFFFF_FFFF : (neg_lo ? (32'd0 - acc[31:0]) : acc[31:0]);
        rem_fix  = neg_hi ? (32'd0 - rem) : rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            div_zero  <= 1'b0;
            a_abs     <= '0;
            b_abs     <= '0;
            cnt       <= '0;
            acc       <= '0;
            rem       <= '0;
            rd_q      <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            wb_wen_o  <= 1'b0;
            wb_addr_o <= '0;
            wb_data_o <= '0;
            hi_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        is_div   <= op_i[1];
                        neg_lo   <= sign_a ^ sign_b;
                        neg_hi   <= op_i[1] ? sign_a : (sign_a ^ sign_b);
                        div_zero <= op_i[1] & (rt_val_i == 32'd0);
                        a_abs    <= a_in;
                        b_abs    <= b_in;
                        // Multiply shifts the multiplier out of acc; divide shifts the dividend out.
                        acc      <= op_i[1] ? {32'd0, a_in} : {32'd0, b_in};
                        rem      <= '0;
                        rd_q     <= rd_addr_i;
                        cnt      <= '0;
                        busy_o   <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        rem        <= rem_ge ? rem_sub : rem_sh[31:0];
                        acc[31:0]  <= {acc[30:0], rem_ge};
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        wb_data_o <= quo_fix;
                        hi_o      <= rem_fix;
                    end else begin
                        wb_data_o <= prod_fix[31:0];
                        hi_o      <= prod_fix[63:32];
                    end
                    wb_addr_o <= rd_q;
                    done_o    <= 1'b1;
                    wb_wen_o  <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done_o   <= 1'b0;
                    wb_wen_o <= 1'b0;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: reference results queued at issue, checked at write-back.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = '0;
    logic [31:0] rs_val_i = '0;
    logic [31:0] rt_val_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        busy_o;
    logic        done_o;
    logic        wb_wen_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] hi_o;

    muldiv_unit #(.raw(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .op_i      (op_i),
        .rs_val_i  (rs_val_i),
        .rt_val_i  (rt_val_i),
        .rd_addr_i (rd_addr_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .wb_wen_o  (wb_wen_o),
        .wb_addr_o (wb_addr_o),
        .wb_data_o (wb_data_o),
        .hi_o      (hi_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] lo;
        logic [31:0] hi;
        int          s;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   accepted = 0;
    int   pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] p;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic signed [31:0] q;
        logic signed [31:0] r;
        case (op)
            2'd0: return {32'd0, a} * {32'd0, b};
            2'd1: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p;
            end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa  = a;
                sbv = b;
                q   = sa / sbv;
                r   = sa % sbv;
                return {r, q};
            end
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (wb_wen_o) begin
            pulses++;
            chk("done_eq_wen", {63'd0, done_o}, 64'd1);
            if (sb.size() == 0) begin
                chk("unexpected_wb", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_addr", {59'd0, wb_addr_o}, {59'd0, e.addr});
                chk("wb_data", {32'd0, wb_data_o}, {32'd0, e.lo});
                chk("hi", {32'd0, hi_o}, {32'd0, e.hi});
                chk("latency", 64'(cyc - e.s), 64'd33);
            end
        end
    end

    // Caller is always at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int s);
        exp_t        e;
        logic [63:0] r;
        int          waited;
        waited = 0;
        s = 0;
        while (busy_o) begin
            @(posedge clk); #1;
            waited++;
            if (waited > 200) begin
                chk("issue_timeout", 64'd1, 64'd0);
                return;
            end
        end
        start_i   = 1'b1;
        op_i      = op;
        rs_val_i  = a;
        rt_val_i  = b;
        rd_addr_i = rd;
        r = ref_model(op, a, b);
        e.addr = rd;
        e.lo   = r[31:0];
        e.hi   = r[63:32];
        e.s    = cyc + 1;
        s      = e.s;
        sb.push_back(e);
        accepted++;
        @(posedge clk); #1;
        start_i   = 1'b0;
        op_i      = 2'($urandom_range(0, 3));
        rs_val_i  = $urandom;
        rt_val_i  = $urandom;
        rd_addr_i = 5'($urandom_range(0, 31));
        chk("busy_after_start", {63'd0, busy_o}, 64'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int last;
        int waited;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        #1;
        chk("rst_flags", {61'd0, busy_o, done_o, wb_wen_o}, 64'd0);
        chk("rst_wb", {27'd0, wb_addr_o, wb_data_o}, 64'd0);
        chk("rst_hi", {32'd0, hi_o}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, s);
        issue(2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 5'd1, s);
        issue(2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 5'd2, s);
        issue(2'd2, 32'd100, 32'd0, 5'd3, s);
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, s);
        issue(2'd3, 32'hFFFF_FFF9, 32'd0, 5'd4, s);

        // Starts during CALC and during DONE must both be dropped.
        issue(2'd2, 32'd1000, 32'd7, 5'd9, s);
        wait_cyc(s + 4);
        start_i = 1'b1; op_i = 2'd0; rs_val_i = 32'd5; rt_val_i = 32'd5; rd_addr_i = 5'd20;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_cyc(s + 33);
        start_i = 1'b1; op_i = 2'd1; rs_val_i = 32'd9; rt_val_i = 32'd3; rd_addr_i = 5'd21;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("busy_drop_e34", {63'd0, busy_o}, 64'd0);
        @(posedge clk); #1;
        chk("done_start_ignored", {63'd0, busy_o}, 64'd0);

        // Reset mid-operation aborts with no write-back.
        issue(2'd1, 32'hFFFF_FFFB, 32'd9, 5'd4, s);
        wait_cyc(s + 10);
        #2 rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        accepted--;
        chk("midrst_flags", {61'd0, busy_o, done_o, wb_wen_o}, 64'd0);
        chk("midrst_wb", {27'd0, wb_addr_o, wb_data_o}, 64'd0);
        chk("midrst_hi", {32'd0, hi_o}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(2'd0, 32'd6, 32'd7, 5'd2, s);

        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            last = s;
            issue(op, a, b, 5'($urandom_range(0, 31)), s);
            if (i > 0) chk("b2b_gap", 64'(s - last), 64'd35);
        end

        waited = 0;
        while (sb.size() > 0 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("pulse_count", 64'(pulses), 64'(accepted));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
